// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg
// Shared definitions for the 4-digit multiplexed 7-segment scan controller:
// FSM state encoding, the active-low segment table indexed by hex value,
// the blanked output constants and a helper that builds the active-low
// digit-enable word for a given digit index.
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Wide enough for slot lengths up to 2^20 cycles.
  localparam int CNT_W = 20;

  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments {g,f,e,d,c,b,a}, index = hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [3:0] digit_enable(input logic [1:0] dig);
    return ~(4'b0001 << dig);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_dec.sv
// seg7_dec
// Combinational hex to 7-segment decoder, active-low outputs.
// Ports:
//   hex - 4-bit value to display
//   seg - active-low segments {g,f,e,d,c,b,a}
module seg7_dec
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit is driven for DIV cycles, followed by DEAD all-off cycles.
// New values are loaded through a valid/ready handshake into a shadow
// register and only become visible at a frame boundary, so a frame never
// shows a mix of old and new digits.
//
// state | meaning
// IDLE  | scanning disabled, display blanked, loads write active directly
// DRIVE | digit dig enabled for DIV cycles
// GAP   | all digits off for DEAD cycles before the next digit
//
// Ports:
//   Clock     - rising-edge clock
//   Resetn    - asynchronous active-low reset
//   Enable    - 1 scans the display, 0 blanks it
//   LZB       - leading-zero blanking enable
//   LoadValid - new-value request
//   LoadData  - four hex nibbles, [3:0] = digit 0 (rightmost)
//   LoadReady - high when a load can be accepted
//   An        - active-low digit enables
//   Seg       - active-low segments {g,f,e,d,c,b,a}
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned DEAD = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic        LZB,
  input  logic        LoadValid,
  input  logic [15:0] LoadData,
  output logic        LoadReady,
  output logic [3:0]  An,
  output logic [6:0]  Seg
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

  state_e           state_q, state_d;
  logic [1:0]       dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             load_acc;
  logic             apply_shadow;
  logic [3:0]       dec_in;
  logic [6:0]       dec_out;
  logic             zero3, zero2, zero1;
  logic             blank;

  assign load_acc = LoadValid && !pending_q;

  always_comb begin
    state_d      = state_q;
    dig_d        = dig_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    apply_shadow = 1'b0;

    if (!Enable) begin
      state_d = IDLE;
      dig_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = DRIVE;
          dig_d        = 2'd0;
          cnt_d        = '0;
          // A load left pending by an interrupted frame lands on restart.
          apply_shadow = pending_q;
        end
        DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == DEAD_LAST) begin
            state_d      = DRIVE;
            cnt_d        = '0;
            dig_d        = dig_q + 2'd1;
            apply_shadow = pending_q && (dig_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          dig_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end

    // apply_shadow needs pending_q=1 and load_acc needs pending_q=0,
    // so these two updates never collide.
    if (apply_shadow) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (load_acc) begin
      if (state_q == IDLE) begin
        active_d = LoadData;
      end else begin
        shadow_d  = LoadData;
        pending_d = 1'b1;
      end
    end
  end

  // Outputs are decoded from next-state values so they register on the
  // same edge as the FSM.
  assign dec_in = active_d[{dig_d, 2'b00} +: 4];

  seg7_dec u_seg7_dec (
    .hex (dec_in),
    .seg (dec_out)
  );

  assign zero3 = (active_d[15:12] == 4'h0);
  assign zero2 = zero3 && (active_d[11:8] == 4'h0);
  assign zero1 = zero2 && (active_d[7:4] == 4'h0);

  always_comb begin
    blank = 1'b0;
    if (LZB) begin
      case (dig_d)
        2'd3:    blank = zero3;
        2'd2:    blank = zero2;
        2'd1:    blank = zero1;
        default: blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if ((state_d == DRIVE) && !blank) begin
      an_d  = digit_enable(dig_d);
      seg_d = dec_out;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      dig_q     <= 2'd0;
      cnt_q     <= '0;
      active_q  <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign LoadReady = ~pending_q;
  assign An        = an_q;
  assign Seg       = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with DIV=4, DEAD=1 (20-cycle frame).
module tb_display_scan_ctrl;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Enable;
  logic        LZB;
  logic        LoadValid;
  logic [15:0] LoadData;
  logic        LoadReady;
  logic [3:0]  An;
  logic [6:0]  Seg;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;

  display_scan_ctrl #(.DIV(4), .DEAD(1)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .LZB       (LZB),
    .LoadValid (LoadValid),
    .LoadData  (LoadData),
    .LoadReady (LoadReady),
    .An        (An),
    .Seg       (Seg)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // n drive cycles of digit d, then the single gap cycle.
  task automatic run_digit(input int d, input int n, input logic [3:0] ean,
                           input logic [6:0] eseg, input bit cseg);
    for (int i = 0; i < n; i++) begin
      tick();
      check_val($sformatf("d%0d_an", d), {28'h0, An}, {28'h0, ean});
      if (cseg) check_val($sformatf("d%0d_seg", d), {25'h0, Seg}, {25'h0, eseg});
    end
    tick();
    check_val($sformatf("d%0d_gap_an", d), {28'h0, An}, 32'hF);
    check_val($sformatf("d%0d_gap_seg", d), {25'h0, Seg}, 32'h7F);
  endtask

  initial begin
    Resetn    = 1'b1;
    Enable    = 1'b0;
    LZB       = 1'b0;
    LoadValid = 1'b0;
    LoadData  = 16'h0000;
    #1 Resetn = 1'b0;
    tick();
    tick();
    check_val("rst_an", {28'h0, An}, 32'hF);
    check_val("rst_seg", {25'h0, Seg}, 32'h7F);
    check_val("rst_rdy", {31'h0, LoadReady}, 32'h1);

    // Default scan of 0000.
    Resetn = 1'b1;
    Enable = 1'b1;
    run_digit(0, 4, 4'b1110, S0, 1'b1);
    run_digit(1, 4, 4'b1101, S0, 1'b1);
    run_digit(2, 4, 4'b1011, S0, 1'b1);
    run_digit(3, 4, 4'b0111, S0, 1'b1);

    // Load 12AF while idle.
    Enable = 1'b0;
    tick();
    check_val("idle_an", {28'h0, An}, 32'hF);
    LoadValid = 1'b1;
    LoadData  = 16'h12AF;
    tick();
    LoadValid = 1'b0;
    check_val("idle_load_rdy", {31'h0, LoadReady}, 32'h1);
    Enable = 1'b1;
    run_digit(0, 4, 4'b1110, SF, 1'b1);
    run_digit(1, 4, 4'b1101, SA, 1'b1);
    run_digit(2, 4, 4'b1011, S2, 1'b1);
    run_digit(3, 4, 4'b0111, S1, 1'b1);

    // Mid-frame load of 5555 with a second load 1234 held behind it.
    run_digit(0, 4, 4'b1110, SF, 1'b1);
    LoadValid = 1'b1;
    LoadData  = 16'h5555;
    check_val("mid_rdy_pre", {31'h0, LoadReady}, 32'h1);
    tick();
    check_val("mid_an", {28'h0, An}, 32'hD);
    check_val("mid_seg", {25'h0, Seg}, {25'h0, SA});
    check_val("mid_rdy0", {31'h0, LoadReady}, 32'h0);
    LoadData = 16'h1234;
    run_digit(1, 3, 4'b1101, SA, 1'b1);
    check_val("mid_rdy1", {31'h0, LoadReady}, 32'h0);
    run_digit(2, 4, 4'b1011, S2, 1'b1);
    check_val("mid_rdy2", {31'h0, LoadReady}, 32'h0);
    run_digit(3, 4, 4'b0111, S1, 1'b1);
    check_val("mid_rdy3", {31'h0, LoadReady}, 32'h0);
    tick();
    check_val("bnd_an", {28'h0, An}, 32'hE);
    check_val("bnd_seg", {25'h0, Seg}, {25'h0, S5});
    check_val("bnd_rdy", {31'h0, LoadReady}, 32'h1);
    tick();
    LoadValid = 1'b0;
    check_val("second_acc_rdy", {31'h0, LoadReady}, 32'h0);
    check_val("second_acc_seg", {25'h0, Seg}, {25'h0, S5});
    run_digit(0, 2, 4'b1110, S5, 1'b1);
    run_digit(1, 4, 4'b1101, S5, 1'b1);
    run_digit(2, 4, 4'b1011, S5, 1'b1);
    run_digit(3, 4, 4'b0111, S5, 1'b1);
    tick();
    check_val("bnd2_seg", {25'h0, Seg}, {25'h0, S4});
    check_val("bnd2_rdy", {31'h0, LoadReady}, 32'h1);

    // Leading-zero blanking with 0070.
    Enable = 1'b0;
    tick();
    check_val("lzb_idle_an", {28'h0, An}, 32'hF);
    LoadValid = 1'b1;
    LoadData  = 16'h0070;
    tick();
    LoadValid = 1'b0;
    LZB    = 1'b1;
    Enable = 1'b1;
    run_digit(0, 4, 4'b1110, S0, 1'b1);
    run_digit(1, 4, 4'b1101, S7, 1'b1);
    run_digit(2, 4, 4'b1111, S0, 1'b0);
    run_digit(3, 4, 4'b1111, S0, 1'b0);

    // Enable dropped in cycle 2 of digit 2.
    LZB = 1'b0;
    run_digit(0, 4, 4'b1110, S0, 1'b1);
    run_digit(1, 4, 4'b1101, S7, 1'b1);
    tick();
    check_val("abort_d2c1_an", {28'h0, An}, 32'hB);
    tick();
    check_val("abort_d2c2_an", {28'h0, An}, 32'hB);
    Enable = 1'b0;
    tick();
    check_val("abort_an", {28'h0, An}, 32'hF);
    check_val("abort_seg", {25'h0, Seg}, 32'h7F);
    tick();
    check_val("abort_hold_an", {28'h0, An}, 32'hF);
    Enable = 1'b1;
    tick();
    check_val("restart_an", {28'h0, An}, 32'hE);
    check_val("restart_seg", {25'h0, Seg}, {25'h0, S0});

    // Async reset during DRIVE with a load pending.
    LoadValid = 1'b1;
    LoadData  = 16'h9999;
    tick();
    LoadValid = 1'b0;
    check_val("pre_rst_rdy", {31'h0, LoadReady}, 32'h0);
    #3 Resetn = 1'b0;
    #1;
    check_val("arst_an", {28'h0, An}, 32'hF);
    check_val("arst_seg", {25'h0, Seg}, 32'h7F);
    check_val("arst_rdy", {31'h0, LoadReady}, 32'h1);
    #2 Resetn = 1'b1;
    tick();
    check_val("post_rst_an", {28'h0, An}, 32'hE);
    check_val("post_rst_seg", {25'h0, Seg}, {25'h0, S0});
    run_digit(0, 3, 4'b1110, S0, 1'b1);
    run_digit(1, 4, 4'b1101, S0, 1'b1);
    run_digit(2, 4, 4'b1011, S0, 1'b1);
    run_digit(3, 4, 4'b0111, S0, 1'b1);
    tick();
    check_val("post_rst_bnd_seg", {25'h0, Seg}, {25'h0, S0});
    check_val("post_rst_bnd_rdy", {31'h0, LoadReady}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the number of Clock cycles each digit is driven (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter DEAD, default 2, SHALL set the number of all-digits-off cycles between consecutive digit slots; legal range 1..255.
REQ-003 Clock  input  1  SHALL be the single rising-edge clock.
REQ-004 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Enable  input  1  SHALL enable scanning when 1; when 0 the display is blanked.
REQ-006 LZB  input  1  SHALL enable leading-zero blanking when 1.
REQ-007 LoadValid  input  1  SHALL be the new-value request.
REQ-008 LoadData  input  16  SHALL carry four hex nibbles; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-009 LoadReady  output  1  SHALL be 1 when a load can be accepted.
REQ-010 An  output  4  SHALL be the active-low digit enables; An[d] selects digit d.
REQ-011 Seg  output  7  SHALL be the active-low segments, ordered {g,f,e,d,c,b,a}.

Function
REQ-012 The FSM SHALL have three states: IDLE, DRIVE, and GAP. It SHALL hold a 2-bit digit index dig and a slot counter cnt.
REQ-013 IDLE transitions:
- IDLE with Enable=1 -> DRIVE, with dig=0 and cnt=0.
- Any state with Enable=0 -> IDLE on the next edge.
REQ-014 DRIVE SHALL last exactly DIV cycles (cnt 0..DIV-1) and then go to GAP with cnt=0.
REQ-015 GAP SHALL last exactly DEAD cycles and then go to DRIVE with dig=dig+1 mod 4, so one frame is 4*(DIV+DEAD) cycles.
REQ-016 An and Seg SHALL be registered and SHALL change on the same edge as the state register.
REQ-017 In DRIVE, the outputs SHALL be:
- An = all ones except An[dig]=0.
- Seg = seg7_dec(active nibble dig).
REQ-018 In IDLE and GAP, the outputs SHALL be An=4'b1111 and Seg=7'b1111111.
REQ-019 Decoder encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 Load handshake:
- LoadReady SHALL equal ~pending.
- A load is accepted on any edge where LoadValid=1 and LoadReady=1.
- LoadData is then captured into shadow, and pending is set to 1.
REQ-021 The shadow value SHALL be copied to the active register, and pending cleared, only at a frame boundary (the GAP->DRIVE edge with dig 3->0).
REQ-022 When the block is in IDLE, an accepted load SHALL write the active register directly, and pending SHALL stay 0.
REQ-023 A load SHALL never alter the active value mid-frame. A load offered while pending=1 SHALL be stalled (not dropped) until LoadReady returns to 1.
REQ-024 With LZB=1, digit d (for d=3..1) SHALL be blanked (An[d] stays 1 during its DRIVE slot) when active nibbles d..3 are all zero. Digit 0 SHALL never be blanked.
REQ-025 If Enable falls mid-slot, the slot SHALL be abandoned. The next Enable=1 SHALL restart at digit 0, and any pending value SHALL be applied on that restart edge.

Reset
REQ-026 While Resetn=0, the block SHALL hold these values:
- state=IDLE, dig=0, cnt=0
- active=16'h0000, shadow=16'h0000, pending=0
- An=4'b1111, Seg=7'b1111111, LoadReady=1
REQ-027 Reset asserted mid-operation SHALL immediately blank the outputs and discard any pending load.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2) and the 16-entry segment constant table.
REQ-029 The decoder SHALL be the sub-module seg7_dec (4-bit in, 7-bit active-low out, combinational), instantiated once and shared across all digits.

Verification (DIV=4, DEAD=1, frame = 20 cycles)
REQ-030 Reset then Enable=1 with no load -> each digit in turn shows Seg=1000000 for 4 cycles with its An bit low, and 1 blank cycle separates digits.
REQ-031 Load 16'h12AF in IDLE, then Enable=1 -> digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001, in that order.
REQ-032 Load 16'h5555 mid-frame, with a second LoadValid held high -> LoadReady=0 until the frame boundary; the new value first appears on digit 0 of the next frame; the second load is accepted one cycle after the boundary.
REQ-033 LZB=1 with active 16'h0070 -> An[3] and An[2] stay 1 during their slots, digit1 shows 1111000, and digit0 shows 1000000.
REQ-034 Enable dropped at cycle 2 of digit 2 -> next edge An=1111; on re-enable, the first driven digit is 0.
REQ-035 Resetn pulsed low during DRIVE with pending=1 -> outputs blank asynchronously and LoadReady=1; after release, the display shows 0000.
